// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus-side driver: register map and FSM states.
package spart_pkg;

  // SPART register addresses on ioaddr
  localparam logic [1:0] SPART_BUF  = 2'b00;
  localparam logic [1:0] SPART_STAT = 2'b01;
  localparam logic [1:0] SPART_DBL  = 2'b10;
  localparam logic [1:0] SPART_DBH  = 2'b11;

  // Driver FSM states
  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    READ,
    ECHO
  } spart_drv_state_t;

endpackage

// File: rtl/key_fifo.sv
// Small synchronous receive FIFO; head byte reads as zero when empty.
module key_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          pop_eff;
  logic          push_eff;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == DEPTH_C);

  // A pop is only real when there is something to pop; a push into a full
  // FIFO is accepted only when a real pop frees a slot in the same cycle.
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);

  assign dout = empty ? 8'h00 : mem[rd_ptr_reg];

  // Storage array write port (no reset on the data itself)
  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr_reg] <= din;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_eff) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_eff)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/spart_driver.sv
// Bus-side SPART controller: programs the baud divisor, reads received bytes
// into a key FIFO, and optionally echoes each byte back to the transmitter.
module spart_driver
  import spart_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV   = 16'h028A,
  parameter int          FIFO_DEPTH = 4,
  parameter bit          ECHO       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cfg_div,
  input  logic        cfg_load,
  output logic        iocs,
  output logic        iorw,
  output logic [1:0]  ioaddr,
  output logic [7:0]  bus_out,
  output logic        bus_oe,
  input  logic [7:0]  bus_in,
  input  logic        rda,
  input  logic        tbr,
  output logic [7:0]  key_data,
  output logic        key_valid,
  input  logic        key_ack,
  output logic        overflow
);

  // The ECHO parameter shadows the ECHO state name, so the state is always
  // referenced with its package prefix in this file.
  spart_drv_state_t state_reg, state_next;

  logic        run_reg;       // low during reset and the first edge after it
  logic [15:0] div_reg;
  logic        cfg_pend_reg;
  logic        echo_pend_reg;
  logic [7:0]  echo_reg;
  logic        overflow_reg;

  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;

  assign fifo_push = (state_reg == READ);
  assign fifo_pop  = key_ack;
  assign key_valid = !fifo_empty;
  assign overflow  = overflow_reg;

  key_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (bus_in),
    .dout (key_data),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Next-state and bus-cycle decode; nothing is driven until run_reg is set
  always_comb begin
    state_next = state_reg;
    iocs       = 1'b0;
    iorw       = 1'b1;
    ioaddr     = SPART_BUF;
    bus_out    = 8'h00;
    bus_oe     = 1'b0;
    if (run_reg) begin
      case (state_reg)
        CFG_LO: begin
          iocs       = 1'b1;
          iorw       = 1'b0;
          ioaddr     = SPART_DBL;
          bus_out    = div_reg[7:0];
          bus_oe     = 1'b1;
          state_next = CFG_HI;
        end
        CFG_HI: begin
          iocs       = 1'b1;
          iorw       = 1'b0;
          ioaddr     = SPART_DBH;
          bus_out    = div_reg[15:8];
          bus_oe     = 1'b1;
          state_next = IDLE;
        end
        IDLE: begin
          // A load arriving this cycle counts as pending so a reprogram is
          // never overtaken by a receive that happens to be waiting.
          if (cfg_pend_reg || cfg_load)      state_next = CFG_LO;
          else if (rda)                      state_next = READ;
          else if (echo_pend_reg && tbr)     state_next = spart_pkg::ECHO;
          else                               state_next = IDLE;
        end
        READ: begin
          iocs       = 1'b1;
          iorw       = 1'b1;
          ioaddr     = SPART_BUF;
          state_next = IDLE;
        end
        spart_pkg::ECHO: begin
          iocs       = 1'b1;
          iorw       = 1'b0;
          ioaddr     = SPART_BUF;
          bus_out    = echo_reg;
          bus_oe     = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM state, divisor latch, echo register and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= CFG_LO;
      run_reg       <= 1'b0;
      div_reg       <= BAUD_DIV;
      cfg_pend_reg  <= 1'b0;
      echo_pend_reg <= 1'b0;
      echo_reg      <= 8'h00;
      overflow_reg  <= 1'b0;
    end else begin
      run_reg   <= 1'b1;
      state_reg <= state_next;

      if (cfg_load) div_reg <= cfg_div;
      // Entering CFG_LO consumes the request; the divisor written there is
      // the newest latched value, so a same-edge load needs no second pass.
      if (state_next == CFG_LO && state_reg != CFG_LO) cfg_pend_reg <= 1'b0;
      else if (cfg_load)                              cfg_pend_reg <= 1'b1;

      if (ECHO && state_reg == READ) begin
        echo_reg      <= bus_in;
        echo_pend_reg <= 1'b1;
      end else if (state_reg == spart_pkg::ECHO) begin
        echo_pend_reg <= 1'b0;
      end

      if (fifo_push && fifo_full && !(key_ack && !fifo_empty)) overflow_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spart_driver.sv
// Self-checking bench for spart_driver: reset/config sequence, receive+echo,
// full-FIFO push/pop, overflow, reconfiguration and reset during echo.
module tb_spart_driver;

  logic        clk;
  logic        rst;
  logic [15:0] cfg_div;
  logic        cfg_load;
  logic        iocs;
  logic        iorw;
  logic [1:0]  ioaddr;
  logic [7:0]  bus_out;
  logic        bus_oe;
  logic [7:0]  bus_in;
  logic        rda;
  logic        tbr;
  logic [7:0]  key_data;
  logic        key_valid;
  logic        key_ack;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_keys[$];

  spart_driver #(
    .BAUD_DIV  (16'h028A),
    .FIFO_DEPTH(4),
    .ECHO      (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_div  (cfg_div),
    .cfg_load (cfg_load),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .bus_out  (bus_out),
    .bus_oe   (bus_oe),
    .bus_in   (bus_in),
    .rda      (rda),
    .tbr      (tbr),
    .key_data (key_data),
    .key_valid(key_valid),
    .key_ack  (key_ack),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus monitor: one line per access, plus the databus-ownership rule
  always @(negedge clk) begin
    if (iocs)
      $display("[%0t] bus %s addr=%0d data=%02h", $time, iorw ? "RD" : "WR", ioaddr,
               iorw ? bus_in : bus_out);
    if (rst) begin
      checks++;
      if (bus_oe !== (iocs && !iorw)) begin
        errors++;
        $display("FAIL bus_oe_rule: bus_oe=%b iocs=%b iorw=%b required bus_oe=iocs&!iorw",
                 bus_oe, iocs, iorw);
      end
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // Present a byte on the SPART side and wait (bounded) for the read cycle
  task automatic send_byte(input logic [7:0] b, input bit expect_push);
    bit seen;
    seen   = 1'b0;
    bus_in = b;
    rda    = 1'b1;
    if (expect_push) exp_keys.push_back(b);
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (iocs && iorw && ioaddr == 2'b00) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL read_cycle_%02h: seen=0 required=1", b);
    end
    @(posedge clk);
    #1 rda = 1'b0;
  endtask

  // Check the FIFO head against the scoreboard and pop it
  task automatic pop_expect();
    logic [7:0] e;
    e = (exp_keys.size() != 0) ? exp_keys.pop_front() : 8'h00;
    @(negedge clk);
    checks++;
    if (key_valid !== 1'b1) begin
      errors++;
      $display("FAIL pop_valid: got %b expected 1", key_valid);
    end
    checks++;
    if (key_data !== e) begin
      errors++;
      $display("FAIL pop_data: got %02h expected %02h", key_data, e);
    end
    $display("[%0t] pop %02h", $time, key_data);
    key_ack = 1'b1;
    @(posedge clk);
    #1 key_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; cfg_div = 16'h0000; cfg_load = 1'b0; bus_in = 8'h00;
    rda = 1'b0; tbr = 1'b1; key_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (iocs !== 1'b0)     begin errors++; $display("FAIL rst_iocs: got %b expected 0", iocs); end
    checks++; if (iorw !== 1'b1)     begin errors++; $display("FAIL rst_iorw: got %b expected 1", iorw); end
    checks++; if (ioaddr !== 2'b00)  begin errors++; $display("FAIL rst_ioaddr: got %0d expected 0", ioaddr); end
    checks++; if (bus_oe !== 1'b0)   begin errors++; $display("FAIL rst_bus_oe: got %b expected 0", bus_oe); end
    checks++; if (bus_out !== 8'h00) begin errors++; $display("FAIL rst_bus_out: got %02h expected 00", bus_out); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rst_key_valid: got %b expected 0", key_valid); end
    checks++; if (key_data !== 8'h00) begin errors++; $display("FAIL rst_key_data: got %02h expected 00", key_data); end
    checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (iocs !== 1'b0) begin errors++; $display("FAIL rst_release_idle: iocs=%b expected 0", iocs); end
    @(negedge clk);
    checks++;
    if (!(iocs === 1'b1 && iorw === 1'b0 && ioaddr === 2'b10 && bus_out === 8'h8A && bus_oe === 1'b1)) begin
      errors++;
      $display("FAIL cfg_lo: iocs=%b iorw=%b addr=%0d data=%02h oe=%b expected 1 0 2 8a 1",
               iocs, iorw, ioaddr, bus_out, bus_oe);
    end
    @(negedge clk);
    checks++;
    if (!(iocs === 1'b1 && iorw === 1'b0 && ioaddr === 2'b11 && bus_out === 8'h02)) begin
      errors++;
      $display("FAIL cfg_hi: iocs=%b iorw=%b addr=%0d data=%02h expected 1 0 3 02",
               iocs, iorw, ioaddr, bus_out);
    end
    @(negedge clk);
    checks++; if (iocs !== 1'b0) begin errors++; $display("FAIL idle_after_cfg: iocs=%b expected 0", iocs); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_receive_echo();
    send_byte(8'h77, 1'b1);
    @(negedge clk);
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL rx_valid: got %b expected 1", key_valid); end
    checks++; if (key_data !== 8'h77) begin errors++; $display("FAIL rx_data: got %02h expected 77", key_data); end
    @(negedge clk);
    checks++;
    if (!(iocs === 1'b1 && iorw === 1'b0 && ioaddr === 2'b00 && bus_out === 8'h77)) begin
      errors++;
      $display("FAIL echo_write: iocs=%b iorw=%b addr=%0d data=%02h expected 1 0 0 77",
               iocs, iorw, ioaddr, bus_out);
    end
    @(posedge clk);
    #1;
    pop_expect();
    @(negedge clk);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rx_empty: key_valid=%b expected 0", key_valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_push_pop();
    bit seen;
    for (int i = 0; i < 4; i++) send_byte(8'h41 + 8'(i), 1'b1);
    seen   = 1'b0;
    bus_in = 8'h4A;
    rda    = 1'b1;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (iocs && iorw && ioaddr == 2'b00) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL full_read_cycle: seen=0 required=1"); end
    checks++;
    if (key_data !== exp_keys[0]) begin
      errors++;
      $display("FAIL full_head: got %02h expected %02h", key_data, exp_keys[0]);
    end
    void'(exp_keys.pop_front());
    exp_keys.push_back(8'h4A);
    key_ack = 1'b1;
    @(posedge clk);
    #1 begin key_ack = 1'b0; rda = 1'b0; end
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_no_overflow: got %b expected 0", overflow); end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) pop_expect();
    @(negedge clk);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL full_count4: key_valid=%b expected 0", key_valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) send_byte(8'h61 + 8'(i), (i < 4));
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b expected 1", overflow); end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) pop_expect();
    @(negedge clk);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: key_valid=%b expected 0", key_valid); end
    checks++; if (key_data !== 8'h00) begin errors++; $display("FAIL ovf_empty_data: got %02h expected 00", key_data); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reconfig();
    repeat (4) @(posedge clk);
    #1;
    cfg_div  = 16'h0145;
    cfg_load = 1'b1;
    bus_in   = 8'h5A;
    rda      = 1'b1;
    exp_keys.push_back(8'h5A);
    @(posedge clk);
    #1 cfg_load = 1'b0;
    @(negedge clk);
    checks++;
    if (!(iocs === 1'b1 && iorw === 1'b0 && ioaddr === 2'b10 && bus_out === 8'h45)) begin
      errors++;
      $display("FAIL recfg_lo: iocs=%b iorw=%b addr=%0d data=%02h expected 1 0 2 45",
               iocs, iorw, ioaddr, bus_out);
    end
    @(negedge clk);
    checks++;
    if (!(iocs === 1'b1 && iorw === 1'b0 && ioaddr === 2'b11 && bus_out === 8'h01)) begin
      errors++;
      $display("FAIL recfg_hi: iocs=%b iorw=%b addr=%0d data=%02h expected 1 0 3 01",
               iocs, iorw, ioaddr, bus_out);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (!(iocs === 1'b1 && iorw === 1'b1 && ioaddr === 2'b00)) begin
      errors++;
      $display("FAIL recfg_read: iocs=%b iorw=%b addr=%0d expected 1 1 0", iocs, iorw, ioaddr);
    end
    @(posedge clk);
    #1 rda = 1'b0;
    pop_expect();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_during_echo();
    tbr = 1'b0;
    send_byte(8'h33, 1'b1);
    tbr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (!(iocs === 1'b1 && iorw === 1'b0 && ioaddr === 2'b00 && bus_out === 8'h33)) begin
      errors++;
      $display("FAIL echo_before_reset: iocs=%b iorw=%b addr=%0d data=%02h expected 1 0 0 33",
               iocs, iorw, ioaddr, bus_out);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (iocs !== 1'b0)   begin errors++; $display("FAIL rst_echo_iocs: got %b expected 0", iocs); end
    checks++; if (bus_oe !== 1'b0) begin errors++; $display("FAIL rst_echo_oe: got %b expected 0", bus_oe); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rst_echo_fifo: key_valid=%b expected 0", key_valid); end
    exp_keys.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (!(iocs === 1'b1 && ioaddr === 2'b10 && bus_out === 8'h8A)) begin
      errors++;
      $display("FAIL rst_cfg_lo: iocs=%b addr=%0d data=%02h expected 1 2 8a", iocs, ioaddr, bus_out);
    end
    @(negedge clk);
    checks++;
    if (!(iocs === 1'b1 && ioaddr === 2'b11 && bus_out === 8'h02)) begin
      errors++;
      $display("FAIL rst_cfg_hi: iocs=%b addr=%0d data=%02h expected 1 3 02", iocs, ioaddr, bus_out);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_receive_echo();
    test_full_push_pop();
    test_overflow();
    test_reconfig();
    test_reset_during_echo();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spart_driver.md
# spart_driver

Bus-side controller for the SPART UART core. After reset it programs the baud divisor through the SPART register port and then services the SPART continuously. Received bytes go into a small FIFO that the CPU drains with a valid/ack handshake, and each byte can optionally be echoed back out the transmitter. It sits between the SPART and the keystroke decoder/CPU, so the decoder and CPU never drive SPART bus cycles.

## Interface
- `BAUD_DIV`, default 16'h028A: divisor loaded after reset (100 MHz clock, 9600 baud, 16x oversampling).
- `FIFO_DEPTH`, default 4: receive FIFO entries; must be a power of 2, at least 2.
- `ECHO`, default 1: 1 means echo every received byte back to the transmitter.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `cfg_div` in 16: new divisor value.
- `cfg_load` in 1: single-cycle pulse; reprogram the divisor from `cfg_div`.
- `iocs` out 1: SPART chip select; high for exactly one cycle per access.
- `iorw` out 1: 1 = read, 0 = write.
- `ioaddr` out 2: register address. 00 = TX/RX buffer, 01 = status, 10 = DB low, 11 = DB high.
- `bus_out` out 8: write data to the SPART.
- `bus_oe` out 1: tristate enable for the shared databus; high only during write cycles.
- `bus_in` in 8: read data from the SPART.
- `rda` in 1: SPART receive data available.
- `tbr` in 1: SPART transmit buffer ready.
- `key_data` out 8: FIFO head byte.
- `key_valid` out 1: FIFO not empty.
- `key_ack` in 1: pop; takes effect only when `key_valid` is high.
- `overflow` out 1: sticky flag; a received byte was dropped because the FIFO was full.

## Operation
- States: CFG_LO, CFG_HI, IDLE, READ, ECHO.
- **CFG_LO**: write cycle to ioaddr 10 with the low byte of the active divisor. Always goes to CFG_HI.
- **CFG_HI**: write cycle to ioaddr 11 with the high byte. Always goes to IDLE.
- **IDLE**: drives no bus cycle. Next state is chosen in this priority order:
  1. `cfg_pend` set → CFG_LO.
  2. `rda` high → READ.
  3. `echo_pend` set and `tbr` high → ECHO.
  4. Otherwise stay in IDLE.
- **READ**: read cycle to ioaddr 00. `bus_in` is captured at the end of the cycle. The SPART clears `rda` on that edge. Always goes to IDLE.
  - Byte is pushed to the FIFO if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise the byte is dropped and `overflow` is set.
  - If `ECHO`=1, the byte is also loaded into the echo register and `echo_pend` is set. A newer byte overwrites an older pending echo.
- **ECHO**: write cycle to ioaddr 00 with the echo register. Clears `echo_pend`. Always goes to IDLE.
- **Divisor source**: the active divisor is `BAUD_DIV` after reset. When `cfg_load` is high in any state, `cfg_div` is latched as the active divisor and `cfg_pend` is set. `cfg_pend` clears on entry to CFG_LO. A second `cfg_load` before the first is serviced overwrites the latched value; only one reprogram sequence runs.
- **Bus defaults**: outside access cycles, `iocs`=0, `iorw`=1, `ioaddr`=00, `bus_oe`=0, `bus_out`=0.
- **FIFO**:
  - `key_data` shows the head entry; it reads 0 when the FIFO is empty.
  - A pop with `key_valid` low is ignored.
  - A pop while the FIFO is empty, coincident with a push, is ignored; the pushed byte stays.

## Timing
- **Reset values**: state = CFG_LO; bus defaults as above; `key_valid`=0; `key_data`=0; `overflow`=0; FIFO empty; `cfg_pend`=0; `echo_pend`=0; active divisor = `BAUD_DIV`.
- **After reset release**: first CFG_LO cycle is the cycle after the first clock edge with `rst`=1. CFG_HI follows, then IDLE on the 3rd cycle.
- **Receive latency**: `rda` high in IDLE at cycle n → READ at n+1 → `key_valid` high and `key_data` = byte at n+2.
- **Pop**: with `key_ack` at cycle n, the next entry (or empty) is visible at n+1.
- **Echo**: fastest write is 2 cycles after READ (READ, IDLE, ECHO). A waiting `rda` always preempts echo.
- **Reset mid-access**: the cycle is abandoned and all bus outputs return to defaults on that edge. FIFO contents are lost, and `BAUD_DIV` is reprogrammed.
- **Bus exclusivity**: `bus_oe` is high only when `iocs`=1 and `iorw`=0.

## Structure
- Package `spart_pkg`:
  - ioaddr constants `SPART_BUF`, `SPART_STAT`, `SPART_DBL`, `SPART_DBH`.
  - State enum `spart_drv_state_t`.
- Sub-module `key_fifo`: synchronous FIFO with `FIFO_DEPTH`, push/pop/full/empty, head output zeroed when empty.
- FSM, config latch, echo register and overflow flag stay in `spart_driver`.

## Test plan
- **Reset sequence**: release `rst` → write 8'h8A to ioaddr 10, then write 8'h02 to ioaddr 11; IDLE by cycle 3; all reset values correct during reset.
- **Receive and echo**: pulse `rda` with `bus_in`=8'h77, `tbr`=1 → one read cycle; `key_data`=8'h77 and `key_valid`=1 two cycles later; write of 8'h77 to ioaddr 00 follows.
- **Overflow**: FIFO_DEPTH=4, push 5 bytes 8'h61..8'h65 with no ack → `overflow`=1; pops return 61,62,63,64, then `key_valid`=0.
- **Simultaneous push/pop when full**: FIFO full, `key_ack` in the READ cycle for 8'h4A → no overflow; count stays 4; 8'h4A is last out.
- **Reconfigure with competing receive**: `cfg_load` with `cfg_div`=16'h0145 while `rda` is high in IDLE → writes 8'h45 to ioaddr 10 and 8'h01 to ioaddr 11 first, then the read cycle.
- **Reset during ECHO**: assert `rst` during ECHO → `iocs`=0 and `bus_oe`=0 on that edge; FIFO empty; CFG sequence with `BAUD_DIV` after release.
